// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, start/data/parity/stop FSM.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int BIT_LEN      = 7,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx_channel_in,
  output logic [BIT_LEN-1:0] rx_data_out,
  output logic               rx_out_vaild,
  output logic               rx_err,
  output logic               rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(BIT_LEN + 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIN     = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [BW-1:0] LASTBIT = BW'(BIT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state;
  logic               sync1, line;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      bit_idx;
  logic [BIT_LEN-1:0] shreg;
  logic               perr, ferr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= rx_channel_in;
      line  <= sync1;
    end
  end

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      rx_data_out  <= '0;
      rx_out_vaild <= 1'b0;
      rx_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!line) begin
          bit_idx <= '0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
          // With one clock per bit the start sample is this very edge
          if (CLKS_PER_BIT == 1) begin
            state        <= DATA;
            cnt          <= '0;
            rx_out_vaild <= 1'b0;
            rx_err       <= 1'b0;
          end else begin
            state <= START;
            cnt   <= CW'(1);
          end
        end
        START: begin
          if (cnt == HALF && line) begin
            state <= IDLE;
          end else begin
            if (cnt == HALF) begin
              rx_out_vaild <= 1'b0;
              rx_err       <= 1'b0;
            end
            if (cnt == LAST) begin
              state <= DATA;
              cnt   <= '0;
            end else cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == HALF) shreg <= (shreg >> 1) | (BIT_LEN'(line) << (BIT_LEN - 1));
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == LASTBIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else bit_idx <= bit_idx + BW'(1);
          end else cnt <= cnt + CW'(1);
        end
        PARITY: begin
          if (cnt == HALF) perr <= line ^ (^shreg);
          if (cnt == LAST) begin
            state <= STOP;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        STOP: begin
          // Frame completes one clock after the stop sample, not at period end
          if (cnt == FIN) begin
            rx_data_out  <= shreg;
            rx_out_vaild <= ~(perr | ferr);
            rx_err       <= perr | ferr;
            state        <= IDLE;
          end else begin
            if (cnt == HALF) ferr <= ~line;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table on a 1-clock/bit receiver plus
// latency, back-to-back, false-start (4 clocks/bit), mid-frame reset and stuck-low sequences.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int F   = 9 + int'(PAR);       // frame bits
  localparam int LAT = 2 + 0 + (F - 1) + 1;  // latency at 1 clock/bit

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx1 = 1'b1, rx4 = 1'b1;
  logic [6:0] data1, data4;
  logic       vld1, err1, busy1, vld4, err4, busy4;

  uart_rx #(.BIT_LEN(7), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rstn(rstn), .rx_channel_in(rx1),
    .rx_data_out(data1), .rx_out_vaild(vld1), .rx_err(err1), .rx_busy(busy1));

  uart_rx #(.BIT_LEN(7), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rstn(rstn), .rx_channel_in(rx4),
    .rx_data_out(data4), .rx_out_vaild(vld4), .rx_err(err4), .rx_busy(busy4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Edge monitor on dut1: captures each completed valid word and counts error reports
  logic [6:0] cap[$];
  int         err_rises = 0;
  logic       vld1_q = 1'b0, err1_q = 1'b0;
  always @(negedge clk) begin
    if (vld1 && !vld1_q) cap.push_back(data1);
    if (err1 && !err1_q) err_rises <= err_rises + 1;
    vld1_q <= vld1;
    err1_q <= err1;
  end

  typedef struct {
    logic [6:0] d;
    bit         pf;
    bit         sb;
    logic [6:0] ed;
    bit         ev;
    bit         ee;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic b, input int c);
    if (sel != 0) rx4 = b; else rx1 = b;
    repeat (c) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the line back at idle
  task automatic send(input int sel, input logic [6:0] d, input bit pflip, input bit sbad);
    int c;
    c = (sel != 0) ? 4 : 1;
    drive(sel, 1'b0, c);
    for (int i = 0; i < 7; i++) drive(sel, d[i], c);
    if (PAR) drive(sel, (^d) ^ pflip, c);
    drive(sel, !sbad, c);
    if (sel != 0) rx4 = 1'b1; else rx1 = 1'b1;
  endtask

  initial begin
    int n0, base;
    vecs[0] = '{7'b1010101, 1'b0, 1'b0, 7'b1010101, 1'b1, 1'b0};
    vecs[1] = '{7'b1010101, 1'b1, 1'b0, 7'b1010101, !PAR, PAR};
    vecs[2] = '{7'b0000000, 1'b0, 1'b1, 7'b0000000, 1'b0, 1'b1};
    vecs[3] = '{7'b1111111, 1'b0, 1'b0, 7'b1111111, 1'b1, 1'b0};
    vecs[4] = '{7'b0110011, 1'b0, 1'b0, 7'b0110011, 1'b1, 1'b0};
    vecs[5] = '{7'b1000000, 1'b1, 1'b1, 7'b1000000, 1'b0, 1'b1};
    vecs[6] = '{7'b0000001, 1'b0, 1'b0, 7'b0000001, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset data", 32'(data1), 0);
    chk("reset vld", 32'(vld1), 0);
    chk("reset err", 32'(err1), 0);
    chk("reset busy", 32'(busy1), 0);
    chk("reset state", 32'(dut1.state), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      send(0, vecs[v].d, vecs[v].pf, vecs[v].sb);
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d data", v), 32'(data1), 32'(vecs[v].ed));
      chk($sformatf("vec%0d vld", v), 32'(vld1), 32'(vecs[v].ev));
      chk($sformatf("vec%0d err", v), 32'(err1), 32'(vecs[v].ee));
      chk($sformatf("vec%0d state", v), 32'(dut1.state), 0);
    end

    // Exact latency: valid still low at LAT-1 edges, high after edge LAT
    send(0, 7'b1010101, 1'b0, 1'b0);
    repeat (LAT - F) @(negedge clk);
    chk("lat vld early", 32'(vld1), 0);
    chk("lat busy", 32'(busy1), 1);
    @(negedge clk);
    chk("lat vld", 32'(vld1), 1);
    chk("lat state", 32'(dut1.state), 0);
    repeat (3) @(negedge clk);

    // Back-to-back: only the mandatory single idle cycle between frames
    base = cap.size();
    send(0, 7'b1111111, 1'b0, 1'b0);
    @(negedge clk);
    send(0, 7'b0000001, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("b2b count", 32'(cap.size() - base), 2);
    if (cap.size() - base == 2) begin
      chk("b2b first", 32'(cap[base]), 32'(7'b1111111));
      chk("b2b second", 32'(cap[base+1]), 32'(7'b0000001));
    end
    chk("b2b vld", 32'(vld1), 1);

    // 4 clocks/bit: good frame, then a one-cycle glitch rejected as false start
    send(1, 7'b0110011, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    chk("c4 data", 32'(data4), 32'(7'b0110011));
    chk("c4 vld", 32'(vld4), 1);
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("fs in start", 32'(dut4.state), 1);
    repeat (2) @(negedge clk);
    chk("fs state", 32'(dut4.state), 0);
    chk("fs vld", 32'(vld4), 1);
    chk("fs err", 32'(err4), 0);
    chk("fs data", 32'(data4), 32'(7'b0110011));

    // Reset in the middle of a frame
    rx1 = 1'b0;
    @(negedge clk);
    rx1 = 1'b1; @(negedge clk);
    rx1 = 1'b1; @(negedge clk);
    rx1 = 1'b0; @(negedge clk);
    chk("pre-rst busy", 32'(busy1), 1);
    rstn = 1'b0;
    rx1 = 1'b1;
    #1;
    chk("rst data", 32'(data1), 0);
    chk("rst vld", 32'(vld1), 0);
    chk("rst err", 32'(err1), 0);
    chk("rst busy", 32'(busy1), 0);
    chk("rst state", 32'(dut1.state), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 7'b0110011, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("post-rst data", 32'(data1), 32'(7'b0110011));
    chk("post-rst vld", 32'(vld1), 1);

    // Line stuck low: repeated frame errors, then recovery
    base = err_rises;
    rx1 = 1'b0;
    repeat (3 * (F + 3)) @(negedge clk);
    chk("stuck err reports>=2", 32'(err_rises - base >= 2), 1);
    rx1 = 1'b1;
    repeat (2 * (F + 3)) @(negedge clk);
    n0 = 0;
    send(0, 7'b1010101, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("recover data", 32'(data1), 32'(7'b1010101));
    chk("recover vld", 32'(vld1), 1);
    chk("recover err", 32'(err1), 32'(n0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BIT_LEN, default 7: number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 1, legal range 1..65535: clock cycles per serial bit.
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port rx_channel_in, input, 1 bit: serial line, idle high.
REQ-006 Port rx_data_out, output, BIT_LEN bits: last received data word.
REQ-007 Port rx_out_vaild, output, 1 bit: last frame received without error.
REQ-008 Port rx_err, output, 1 bit: last frame had a parity error or a stop-bit error.
REQ-009 Port rx_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 Frame format: start bit 0, then BIT_LEN data bits LSB first, then an even-parity bit (when enabled, see REQ-024), then stop bit 1.
REQ-011 rx_channel_in shall pass through a 2-flop synchronizer; all decisions use the synchronized signal.
REQ-012 State register named state, 3 bits; encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; state is nonzero for the whole duration of a frame.
REQ-013 Bit period 0 begins on the first edge where the synchronized line is seen low in IDLE; each bit is sampled at cycle floor(CLKS_PER_BIT/2) of its period.
REQ-014 START: if the line samples high at the sample point, this is a false start; return to IDLE and leave all outputs unchanged.
REQ-015 DATA: shift in BIT_LEN samples with an internal bit counter, then go to PARITY (or to STOP when parity is disabled).
REQ-016 PARITY: compare the sample with the XOR of the data bits; a mismatch sets an internal parity-error flag.
REQ-017 STOP: a sample of 0 sets an internal frame-error flag.
REQ-018 On the clock following the stop sample, all of the following happen together:
- rx_data_out is loaded with the received word, even on error.
- rx_out_vaild is set to 1 when neither error flag is set, otherwise 0.
- rx_err is set to the OR of the two error flags.
- state returns to IDLE.
REQ-019 rx_out_vaild and rx_err shall hold their values until the next valid start (passing the REQ-014 check), which clears both; rx_data_out holds until the next frame completes.
REQ-020 Latency: rx_out_vaild rises 2 + floor(CLKS_PER_BIT/2) + (FRAME_BITS-1)*CLKS_PER_BIT + 1 cycles after the start-bit edge at the pin, where FRAME_BITS = BIT_LEN+3 (parity on) or BIT_LEN+2 (parity off); this is 12 cycles for the defaults.
REQ-021 Back-to-back frames: a low line in the first IDLE cycle after a frame completes shall start the next frame with no dead cycle beyond IDLE itself.
REQ-022 A line held low forever shall produce repeated frame errors; the receiver shall never lock up.

Reset
REQ-023 While rstn is low, and immediately on its falling edge (including mid-frame):
- state = IDLE.
- rx_data_out = 0, rx_out_vaild = 0, rx_err = 0, rx_busy = 0.
- Counters cleared, synchronizer flops set to 1.
- A partially received frame is discarded.

Configuration
REQ-024 Macro UART_RX_PARITY_EN:
- Defined: the parity bit is expected and checked per REQ-016.
- Undefined: the frame carries no parity bit, the PARITY state is never entered, and rx_err reflects the stop-bit error only.

Verification
REQ-025 Defaults, parity on: frame with data 1010101, parity 0, stop 1 -> 12 cycles after the start edge rx_data_out=1010101, rx_out_vaild=1, rx_err=0, state=0.
REQ-026 Same frame with the parity bit flipped to 1 -> rx_data_out=1010101, rx_out_vaild=0, rx_err=1.
REQ-027 Frame with data 0000000 and stop bit 0 -> rx_out_vaild=0, rx_err=1; the receiver then accepts a following correct frame of 1111111 (parity 1) with rx_out_vaild=1.
REQ-028 CLKS_PER_BIT=4: line low for 1 cycle then high -> state returns to 0 within 4 cycles; rx_out_vaild, rx_err and rx_data_out are unchanged.
REQ-029 Assert rstn low after the 3rd data bit of a frame -> all outputs 0 and state 0 immediately; after release, a full frame of 0110011 is received with rx_out_vaild=1.
REQ-030 Two back-to-back frames, 1111111 then 0000001 -> each is reported in turn with rx_out_vaild=1 and no frame lost.
